// File: rtl/iab_arb_pkg.sv
// Shared constants, state encoding and helpers for the IAB bus arbiter.
package iab_arb_pkg;

  localparam int N_REQ       = 4;
  localparam int BURST_LEN   = 8;
  localparam int TIMEOUT_CYC = 16;
  localparam int IDX_W       = 2;
  localparam int BEAT_W      = 3;
  localparam int TO_W        = 5;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [TO_W-1:0]   LAST_IDLE = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } arbState_e;

  function automatic logic [N_REQ-1:0] idxToOneHot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/iab_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_pick
  import iab_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  logic [IDX_W-1:0] cand_s;

  // Scan from the farthest offset down so the closest candidate to ptr wins.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    cand_s = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand_s = ptr + IDX_W'(i);
      valid  = valid | req[cand_s];
      winner = req[cand_s] ? cand_s : winner;
    end
  end

endmodule

// File: rtl/iab_arbiter.sv
// Round-robin IAB arbiter granting fixed 8-beat bursts separated by a GAP cycle.
// Optional burst watchdog enabled with macro IAB_ARB_TIMEOUT_EN.
module iab_arbiter
  import iab_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0][7:0] data_in,
  input  logic                  acceptedI,
  output logic [N_REQ-1:0]      gnt,
  output logic [7:0]            bus_data,
  output logic [IDX_W-1:0]      owner,
`ifdef IAB_ARB_TIMEOUT_EN
  output logic                  timeout_err,
`endif
  output logic                  busy
);

  arbState_e         state_r, nextState_s;
  logic [N_REQ-1:0]  gnt_r, gntNext_s;
  logic [IDX_W-1:0]  owner_r, ownerNext_s;
  logic [IDX_W-1:0]  ptr_r, ptrNext_s;
  logic [BEAT_W-1:0] beatCnt_r, beatNext_s;
  logic              pickValid_s;
  logic [IDX_W-1:0]  pickWinner_s;
  logic              burstEnd_s;
  logic              leave_s;

  rr_pick uPick (
    .req    (req),
    .ptr    (ptr_r),
    .valid  (pickValid_s),
    .winner (pickWinner_s)
  );

  assign burstEnd_s = (state_r == BURST) && acceptedI && (beatCnt_r == LAST_BEAT);

`ifdef IAB_ARB_TIMEOUT_EN
  logic [TO_W-1:0] idleCnt_r, idleNext_s;
  logic            timeoutHit_s;
  logic            timeoutErr_r;

  assign timeoutHit_s = (state_r == BURST) && !acceptedI && (idleCnt_r == LAST_IDLE);
  assign leave_s      = burstEnd_s | timeoutHit_s;
  assign timeout_err  = timeoutErr_r;

  // Idle-beat count: zero outside BURST (so BURST entry starts clean) and on every accept.
  always_comb begin
    if ((state_r != BURST) || acceptedI || timeoutHit_s) begin
      idleNext_s = '0;
    end else begin
      idleNext_s = idleCnt_r + 5'd1;
    end
  end

  // Watchdog counter and one-cycle error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idleCnt_r    <= '0;
      timeoutErr_r <= 1'b0;
    end else begin
      idleCnt_r    <= idleNext_s;
      timeoutErr_r <= timeoutHit_s;
    end
  end
`else
  assign leave_s = burstEnd_s;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE:    nextState_s = pickValid_s ? BURST : IDLE;
      BURST:   nextState_s = leave_s ? GAP : BURST;
      GAP:     nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // FSM outputs: next values of grant, owner, beat counter and pointer.
  always_comb begin
    gntNext_s   = gnt_r;
    ownerNext_s = owner_r;
    beatNext_s  = beatCnt_r;
    ptrNext_s   = ptr_r;
    case (state_r)
      IDLE: begin
        if (pickValid_s) begin
          gntNext_s   = idxToOneHot(pickWinner_s);
          ownerNext_s = pickWinner_s;
          beatNext_s  = '0;
        end else begin
          gntNext_s   = '0;
          ownerNext_s = '0;
          beatNext_s  = '0;
        end
      end
      BURST: begin
        if (leave_s) begin
          gntNext_s   = '0;
          ownerNext_s = '0;
          beatNext_s  = '0;
          ptrNext_s   = owner_r + 2'd1;
        end else if (acceptedI) begin
          beatNext_s  = beatCnt_r + 3'd1;
        end else begin
          beatNext_s  = beatCnt_r;
        end
      end
      GAP: begin
        gntNext_s   = '0;
        ownerNext_s = '0;
        beatNext_s  = '0;
      end
      default: begin
        gntNext_s   = '0;
        ownerNext_s = '0;
        beatNext_s  = '0;
        ptrNext_s   = '0;
      end
    endcase
  end

  // Registered grant, owner, beat counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_r     <= '0;
      owner_r   <= '0;
      beatCnt_r <= '0;
      ptr_r     <= '0;
    end else begin
      gnt_r     <= gntNext_s;
      owner_r   <= ownerNext_s;
      beatCnt_r <= beatNext_s;
      ptr_r     <= ptrNext_s;
    end
  end

  // Byte mux on the registered one-hot grant; all-zero grant yields 8'h00.
  always_comb begin
    bus_data = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      bus_data = bus_data | (data_in[i] & {8{gnt_r[i]}});
    end
  end

  assign gnt   = gnt_r;
  assign owner = owner_r;
  assign busy  = (state_r == BURST);

endmodule

// File: tb/tb_iab_arbiter.sv
// Self-checking bench for iab_arbiter; bus bytes are scoreboarded through a queue.
module tb_iab_arbiter;

  logic            clk;
  logic            rst_n;
  logic [3:0]      req;
  logic [3:0][7:0] data_in;
  logic            acceptedI;
  logic [3:0]      gnt;
  logic [7:0]      bus_data;
  logic [1:0]      owner;
  logic            busy;
`ifdef IAB_ARB_TIMEOUT_EN
  logic            timeout_err;
`endif

  int         errors;
  int         checks;
  logic [7:0] expQ[$];

  iab_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data_in   (data_in),
    .acceptedI (acceptedI),
    .gnt       (gnt),
    .bus_data  (bus_data),
    .owner     (owner),
`ifdef IAB_ARB_TIMEOUT_EN
    .timeout_err (timeout_err),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkGnt(input string name, input logic [3:0] exp);
    checks++;
    if (gnt !== exp) begin
      errors++;
      $display("FAIL %s: gnt=%b expected %b", name, gnt, exp);
    end
  endtask

  // Drives 8 accepted beats for the current owner, scoreboarding every byte.
  task automatic runBurst(input int ownerIdx, input int dropAt, input logic [7:0] base);
    logic [3:0] expG;
    logic [7:0] val;
    logic [7:0] want;
    expG = 4'b0001 << ownerIdx;
    for (int b = 0; b < 8; b++) begin
      if (b == dropAt) req = 4'b0000;
      for (int k = 0; k < 4; k++) data_in[k] = 8'($urandom_range(0, 255));
      val = base + 8'(17 * (b + 1));
      data_in[ownerIdx] = val;
      expQ.push_back(val);
      acceptedI = 1'b1;
      #1;
      want = expQ.pop_front();
      checks++;
      if (bus_data !== want) begin
        errors++;
        $display("FAIL burst_data owner=%0d beat=%0d: bus_data=%h expected %h", ownerIdx, b, bus_data, want);
      end
      checks++;
      if (gnt !== expG || busy !== 1'b1 || owner !== 2'(ownerIdx)) begin
        errors++;
        $display("FAIL burst_hold owner=%0d beat=%0d: gnt=%b busy=%b owner=%0d expected gnt=%b busy=1 owner=%0d",
                 ownerIdx, b, gnt, busy, owner, expG, ownerIdx);
      end
      tick();
    end
    acceptedI = 1'b0;
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0 || bus_data !== 8'h00) begin
      errors++;
      $display("FAIL burst_end owner=%0d: gnt=%b busy=%b owner=%0d bus_data=%h expected 0000/0/0/00",
               ownerIdx, gnt, busy, owner, bus_data);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req = 4'b0000; acceptedI = 1'b0;
    data_in = {8'hA5, 8'h5A, 8'h3C, 8'hC3};
    #3;
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0 || bus_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: gnt=%b busy=%b owner=%0d bus_data=%h expected 0000/0/0/00", gnt, busy, owner, bus_data);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checkGnt("idle_no_req", 4'b0000);
  endtask

  task automatic test_fairness;
    req = 4'b1111;
    tick();
    for (int n = 0; n < 5; n++) begin
      checkGnt("fair_grant", 4'b0001 << (n % 4));
      runBurst(n % 4, -1, 8'(n * 3));
      if (n == 4) req = 4'b0000;
      tick();
      checkGnt("fair_gap2", 4'b0000);
      tick();
    end
    checkGnt("fair_idle_after", 4'b0000);
  endtask

  task automatic test_wrap;
    req = 4'b0100;
    tick();
    checkGnt("wrap_owner2", 4'b0100);
    runBurst(2, -1, 8'h20);
    req = 4'b0101;
    tick();
    checkGnt("wrap_gap2", 4'b0000);
    tick();
    checkGnt("wrap_to0", 4'b0001);
    runBurst(0, -1, 8'h30);
    tick();
    tick();
    checkGnt("wrap_then2", 4'b0100);
    runBurst(2, -1, 8'h50);
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_idle_accept;
    acceptedI = 1'b1;
    data_in = {8'hFF, 8'hEE, 8'hDD, 8'hCC};
    repeat (3) begin
      tick();
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || bus_data !== 8'h00) begin
        errors++;
        $display("FAIL idle_accept: gnt=%b busy=%b bus_data=%h expected 0000/0/00", gnt, busy, bus_data);
      end
    end
    acceptedI = 1'b0;
  endtask

  task automatic test_single;
    req = 4'b0010;
    tick();
    checkGnt("single_latency", 4'b0010);
    checks++;
    if (owner !== 2'd1) begin
      errors++;
      $display("FAIL single_owner: owner=%0d expected 1", owner);
    end
    runBurst(1, -1, 8'h00);
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_drop;
    req = 4'b1000;
    tick();
    checkGnt("drop_grant", 4'b1000);
    runBurst(3, 3, 8'h40);
    tick();
    tick();
    checkGnt("drop_idle", 4'b0000);
  endtask

`ifdef IAB_ARB_TIMEOUT_EN
  task automatic test_timeout;
    req = 4'b0011;
    tick();
    checkGnt("to_grant0", 4'b0001);
    for (int k = 1; k < 16; k++) begin
      tick();
      checks++;
      if (gnt !== 4'b0001 || timeout_err !== 1'b0) begin
        errors++;
        $display("FAIL to_wait cyc=%0d: gnt=%b timeout_err=%b expected 0001/0", k, gnt, timeout_err);
      end
    end
    tick();
    checks++;
    if (gnt !== 4'b0000 || timeout_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL to_abort: gnt=%b timeout_err=%b busy=%b expected 0000/1/0", gnt, timeout_err, busy);
    end
    tick();
    checks++;
    if (gnt !== 4'b0000 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse: gnt=%b timeout_err=%b expected 0000/0", gnt, timeout_err);
    end
    tick();
    checkGnt("to_next1", 4'b0010);
    req = 4'b0000;
    runBurst(1, -1, 8'h60);
    tick();
    tick();
  endtask
`else
  task automatic test_no_timeout;
    req = 4'b0011;
    tick();
    checkGnt("nto_grant0", 4'b0001);
    repeat (20) begin
      tick();
      checks++;
      if (gnt !== 4'b0001 || busy !== 1'b1) begin
        errors++;
        $display("FAIL nto_hold: gnt=%b busy=%b expected 0001/1", gnt, busy);
      end
    end
    req = 4'b0000;
    runBurst(0, -1, 8'h60);
    tick();
    tick();
  endtask
`endif

  task automatic test_reset_mid;
    req = 4'b0100;
    tick();
    checkGnt("rmid_grant", 4'b0100);
    data_in[2] = 8'h77;
    acceptedI = 1'b1;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0 || bus_data !== 8'h00) begin
      errors++;
      $display("FAIL rmid_async: gnt=%b busy=%b owner=%0d bus_data=%h expected 0000/0/0/00", gnt, busy, owner, bus_data);
    end
    acceptedI = 1'b0;
    req = 4'b0000;
    tick();
    rst_n = 1'b1;
    req = 4'b1000;
    tick();
    checkGnt("rmid_regrant", 4'b1000);
    req = 4'b0000;
    runBurst(3, -1, 8'h70);
    tick();
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_fairness();
    test_wrap();
    test_idle_accept();
    test_single();
    test_drop();
`ifdef IAB_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
